// File: rtl/serial_adder.sv
// Bit-serial adder: one bit of saOp1 + saOp2 + saCi per clock, LSB first,
// with registered result/carry and a one-cycle saDone pulse per completed sum.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             saClk,
    input  logic             saRstN,
    input  logic             saStart,
    input  logic [WIDTH-1:0] saOp1,
    input  logic [WIDTH-1:0] saOp2,
    input  logic             saCi,
    output logic             saBusy,
    output logic             saDone,
    output logic [WIDTH-1:0] saRes,
    output logic             saCo
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
        $error("serial_adder: WIDTH must be in 1..32");
    end

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sum_bit;
    logic             carry_bit;
    logic [WIDTH-1:0] acc_shift;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        co_d      = co_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
        carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
        acc_shift            = acc_q >> 1;
        acc_shift[WIDTH-1]   = sum_bit;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (saStart) begin
                    a_d     = saOp1;
                    b_d     = saOp2;
                    c_d     = saCi;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry_bit;
                acc_d = acc_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    res_d   = acc_shift;
                    co_d    = carry_bit;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge saClk or negedge saRstN) begin
        if (!saRstN) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign saBusy = busy_q;
    assign saDone = done_q;
    assign saRes  = res_q;
    assign saCo   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 1 and 32: constant vector
// table, directed multi-cycle sequences and random operands against a + b + ci.
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic        start8, ci8, busy8, done8, co8;
    logic [7:0]  a8, b8, res8;
    logic        start1, ci1, busy1, done1, co1;
    logic [0:0]  a1, b1, res1;
    logic        start32, ci32, busy32, done32, co32;
    logic [31:0] a32, b32, res32;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .saClk(clk), .saRstN(rst_n), .saStart(start8), .saOp1(a8), .saOp2(b8),
        .saCi(ci8), .saBusy(busy8), .saDone(done8), .saRes(res8), .saCo(co8)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .saClk(clk), .saRstN(rst_n), .saStart(start1), .saOp1(a1), .saOp2(b1),
        .saCi(ci1), .saBusy(busy1), .saDone(done1), .saRes(res1), .saCo(co1)
    );
    serial_adder #(.WIDTH(32)) dut32 (
        .saClk(clk), .saRstN(rst_n), .saStart(start32), .saOp1(a32), .saOp2(b32),
        .saCi(ci32), .saBusy(busy32), .saDone(done32), .saRes(res32), .saCo(co32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] res;
        logic       co;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        case (w)
            1: begin start1 = s; a1 = a[0:0]; b1 = b[0:0]; ci1 = c; end
            8: begin start8 = s; a8 = a[7:0]; b8 = b[7:0]; ci8 = c; end
            default: begin start32 = s; a32 = a; b32 = b; ci32 = c; end
        endcase
    endtask

    function automatic logic done_of(input int w);
        return (w == 1) ? done1 : (w == 8) ? done8 : done32;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 1) ? busy1 : (w == 8) ? busy8 : busy32;
    endfunction
    function automatic logic co_of(input int w);
        return (w == 1) ? co1 : (w == 8) ? co8 : co32;
    endfunction
    function automatic logic [31:0] res_of(input int w);
        return (w == 1) ? {31'b0, res1} : (w == 8) ? {24'b0, res8} : res32;
    endfunction

    // Reference: plain (w+1)-bit addition of the masked operands.
    function automatic logic [32:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
        logic [32:0] mask;
        mask = (33'd1 << w) - 33'd1;
        return ((({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'b0, c}) & ((mask << 1) | 33'd1));
    endfunction

    // Starts one addition, scrambles the inputs during RUN, waits for saDone
    // (bounded) and checks the pulse drops after one cycle with the result held.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                          output logic [31:0] r, output logic co, output int lat, output int bc);
        drive(w, 1'b1, a, b, c);
        tick();
        drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(1)));
        lat = 0;
        bc  = 0;
        while (!done_of(w) && lat < 200) begin
            if (busy_of(w)) bc++;
            tick();
            lat++;
        end
        if (!done_of(w)) check($sformatf("w%0d_done_timeout", w), 64'd0, 64'd1);
        check($sformatf("w%0d_busy_with_done", w), {63'b0, busy_of(w)}, 64'd0);
        r  = res_of(w);
        co = co_of(w);
        tick();
        check($sformatf("w%0d_done_one_cycle", w), {63'b0, done_of(w)}, 64'd0);
        check($sformatf("w%0d_res_held_idle", w), {31'b0, co_of(w), res_of(w)}, {31'b0, co, r});
    endtask

    initial begin
        vec_t        tbl[8];
        logic [31:0] r, ra, rb;
        logic        co, rc;
        logic [32:0] exp;
        int          lat, bc, pulses;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{8'h5A, 8'h25, 1'b1, 8'h80, 1'b0};
        tbl[2] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        tbl[3] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        rst_n = 1'b0;
        drive(1, 1'b0, 0, 0, 1'b0);
        drive(32, 1'b0, 0, 0, 1'b0);
        drive(8, 1'b1, 32'h12, 32'h34, 1'b1);
        #3;
        check("reset_outputs_w8", {54'b0, busy8, done8, co8, res8}, 64'd0);
        check("reset_outputs_w32", {29'b0, busy32, done32, co32, res32}, 64'd0);
        // Start held high across edges while in reset must not be taken.
        tick();
        tick();
        check("start_ignored_in_reset", {62'b0, busy8, done8}, 64'd0);
        drive(8, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", {62'b0, busy8, done8}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(8, {24'b0, tbl[i].a}, {24'b0, tbl[i].b}, tbl[i].ci, r, co, lat, bc);
            check($sformatf("tbl%0d_sum", i), {55'b0, co, r[7:0]}, {55'b0, tbl[i].co, tbl[i].res});
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd8);
            check($sformatf("tbl%0d_busy_cycles", i), 64'(bc), 64'd8);
        end

        // Restart attempt mid-RUN is ignored; back-to-back start from DONE.
        drive(8, 1'b1, 32'h10, 32'h20, 1'b0);
        tick();
        drive(8, 1'b0, 0, 0, 1'b0);
        tick();
        tick();
        drive(8, 1'b1, 32'h77, 32'h77, 1'b1);
        tick();
        drive(8, 1'b0, 0, 0, 1'b0);
        lat = 3;
        while (!done8 && lat < 100) begin tick(); lat++; end
        check("restart_ignored_latency", 64'(lat), 64'd8);
        check("restart_ignored_sum", {55'b0, co8, res8}, {55'b0, 1'b0, 8'h30});
        drive(8, 1'b1, 32'h01, 32'h01, 1'b0);
        tick();
        drive(8, 1'b0, 32'hFF, 32'hFF, 1'b1);
        check("b2b_busy", {62'b0, busy8, done8}, 64'd2);
        check("b2b_res_held_run", {56'b0, res8}, 64'h30);
        lat = 0;
        pulses = 0;
        while (!done8 && lat < 100) begin tick(); lat++; end
        check("b2b_latency", 64'(lat), 64'd8);
        check("b2b_sum", {55'b0, co8, res8}, {55'b0, 1'b0, 8'h02});

        // Asynchronous reset in the middle of RUN.
        tick();
        drive(8, 1'b1, 32'hAA, 32'h55, 1'b0);
        tick();
        drive(8, 1'b0, 0, 0, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {54'b0, busy8, done8, co8, res8}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) pulses++;
        end
        check("no_done_after_abort", 64'(pulses), 64'd0);
        run_op(8, 32'h03, 32'h04, 1'b0, r, co, lat, bc);
        check("after_abort_sum", {55'b0, co, r[7:0]}, {55'b0, 1'b0, 8'h07});

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1));
            exp = model(8, ra, rb, rc);
            run_op(8, ra, rb, rc, r, co, lat, bc);
            check($sformatf("rand8_%0d", i), {55'b0, co, r[7:0]}, {31'b0, exp});
            check($sformatf("rand8_%0d_lat", i), 64'(lat), 64'd8);
        end

        for (int i = 0; i < 8; i++) begin
            ra = 32'(i & 1);
            rb = 32'((i >> 1) & 1);
            rc = 1'((i >> 2) & 1);
            exp = model(1, ra, rb, rc);
            run_op(1, ra, rb, rc, r, co, lat, bc);
            check($sformatf("w1_%0d_sum", i), {62'b0, co, r[0]}, {31'b0, exp});
            check($sformatf("w1_%0d_latency", i), 64'(lat), 64'd1);
        end

        run_op(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, co, lat, bc);
        check("w32_max_sum", {31'b0, co, r}, {31'b0, 1'b1, 32'hFFFF_FFFF});
        check("w32_max_latency", 64'(lat), 64'd32);
        check("w32_max_busy", 64'(bc), 64'd32);
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1));
            exp = model(32, ra, rb, rc);
            run_op(32, ra, rb, rc, r, co, lat, bc);
            check($sformatf("rand32_%0d", i), {31'b0, co, r}, {31'b0, exp});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
